// File: rtl/axi_delay_ctrl_if.sv
// Per-channel AXI handshake bundle seen by the delay controller.
// Bit order on every vector: 0 AW, 1 W, 2 B, 3 AR, 4 R.
interface axi_delay_ctrl_if;
  logic [4:0] ch_valid_i;
  logic [4:0] ch_ready_i;
  logic [4:0] ch_pass_o;

  modport master (
    output ch_valid_i,
    output ch_ready_i,
    input  ch_pass_o
  );

  modport slave (
    input  ch_valid_i,
    input  ch_ready_i,
    output ch_pass_o
  );
endinterface

// File: rtl/axi_delay_ctrl.sv
// axi_delay_ctrl: per-channel valid/ready delay injector with fixed or LFSR-random delays.
// Defining AXI_DELAY_CTRL_STATS_EN adds a saturating stall-cycle counter on stall_cycles_o.
module axi_delay_ctrl #(
  parameter int          MaxOutstanding = 8,
  parameter logic [15:0] SeedDefault    = 16'hACE1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      cfg_mode_i,
  input  logic [3:0]      cfg_delay_i,
  input  logic [15:0]     seed_i,
  input  logic            seed_load_i,
  axi_delay_ctrl_if.slave ch,
  output logic [3:0]      aw_outstanding_o,
  output logic [31:0]     stall_cycles_o
);

  typedef enum logic [1:0] {IDLE, WAIT, PASS} state_e;

  localparam logic [3:0] MaxOut = 4'(MaxOutstanding);

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] sat_count(input logic [3:0] v, input logic inc, input logic dec);
    if (inc && !dec && (v != 4'hF)) return v + 4'd1;
    if (dec && !inc && (v != 4'h0)) return v - 4'd1;
    return v;
  endfunction

  logic [15:0] lfsr_q;
  state_e      state_q [5];
  state_e      state_d [5];
  logic [3:0]  cnt_q   [5];
  logic [3:0]  cnt_d   [5];
  logic [4:0]  fsm_pass;
  logic [4:0]  hs;
  logic [3:0]  dly     [5];
  logic        bypass;
  logic        aw_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SeedDefault;
    end else if (seed_load_i) begin
      lfsr_q <= (seed_i == 16'h0000) ? SeedDefault : seed_i;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Pass gating: bypass overrides the FSMs, but the AW throttle applies in every mode.
  always_comb begin
    bypass  = (cfg_mode_i == 2'd0) || (cfg_mode_i == 2'd3);
    aw_full = (aw_outstanding_o == MaxOut);
    for (int i = 0; i < 5; i++) begin
      fsm_pass[i] = (state_q[i] == PASS);
    end
    ch.ch_pass_o = '0;
    if (rst_ni) begin
      ch.ch_pass_o = (bypass ? 5'b11111 : fsm_pass) & ~{4'b0000, aw_full};
    end
    hs = ch.ch_valid_i & ch.ch_ready_i & ch.ch_pass_o;
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      dly[i]     = (cfg_mode_i == 2'd2) ? (lfsr_q[3*i +: 4] & cfg_delay_i) : cfg_delay_i;
      if (bypass) begin
        state_d[i] = IDLE;
        cnt_d[i]   = 4'd0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (ch.ch_valid_i[i]) begin
              if (dly[i] == 4'd0) begin
                state_d[i] = PASS;
              end else begin
                state_d[i] = WAIT;
                cnt_d[i]   = dly[i] - 4'd1;
              end
            end
          end
          WAIT: begin
            if (!ch.ch_valid_i[i]) begin
              state_d[i] = IDLE;
            end else if (cnt_q[i] == 4'd0) begin
              state_d[i] = PASS;
            end else begin
              cnt_d[i] = cnt_q[i] - 4'd1;
            end
          end
          PASS: begin
            if (!ch.ch_valid_i[i] || hs[i]) begin
              state_d[i] = IDLE;
            end
          end
          default: begin
            state_d[i] = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_outstanding_o <= 4'd0;
    end else begin
      aw_outstanding_o <= sat_count(aw_outstanding_o, hs[0], hs[2]);
    end
  end

`ifdef AXI_DELAY_CTRL_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cycles_o <= 32'd0;
    end else if (|(ch.ch_valid_i & ~ch.ch_pass_o) && (stall_cycles_o != 32'hFFFF_FFFF)) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_axi_delay_ctrl.sv
// Self-checking bench for axi_delay_ctrl: scoreboard queue of expected values per scenario.
module tb_axi_delay_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [3:0]  cfg_delay = 4'd0;
  logic [15:0] seed = 16'd0;
  logic        seed_load = 1'b0;
  logic [3:0]  aw_out;
  logic [31:0] stall;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  logic [15:0] m_lfsr;

  axi_delay_ctrl_if bus ();

  axi_delay_ctrl dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .cfg_mode_i       (cfg_mode),
    .cfg_delay_i      (cfg_delay),
    .seed_i           (seed),
    .seed_load_i      (seed_load),
    .ch               (bus.slave),
    .aw_outstanding_o (aw_out),
    .stall_cycles_o   (stall)
  );

  always #5 clk = ~clk;

  // Reference Galois LFSR, taps 16'hB400, shifting right.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1;
    end else if (seed_load) begin
      m_lfsr <= (seed == 16'h0) ? 16'hACE1 : seed;
    end else begin
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ch_valid_i = '0;
    bus.ch_ready_i = '1;
    seed_load = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.ch_valid_i = '0;
    bus.ch_ready_i = '1;
    cfg_mode = 2'd1;
    #1;
    n_checks++;
    if (bus.ch_pass_o !== 5'b00000) begin
      n_fail++; $display("FAIL reset_pass: got %b want 00000", bus.ch_pass_o);
    end
    n_checks++;
    if (aw_out !== 4'd0) begin
      n_fail++; $display("FAIL reset_outstanding: got %0d want 0", aw_out);
    end
    n_checks++;
    if (stall !== 32'd0) begin
      n_fail++; $display("FAIL reset_stall: got %0d want 0", stall);
    end
    cfg_mode = 2'd0;
    #1;
    n_checks++;
    if (bus.ch_pass_o !== 5'b00000) begin
      n_fail++; $display("FAIL reset_pass_bypass: got %b want 00000", bus.ch_pass_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.ch_pass_o !== 5'b11111) begin
      n_fail++; $display("FAIL bypass_mode0: got %b want 11111", bus.ch_pass_o);
    end
    cfg_mode = 2'd3;
    #1;
    n_checks++;
    if (bus.ch_pass_o !== 5'b11111) begin
      n_fail++; $display("FAIL bypass_mode3: got %b want 11111", bus.ch_pass_o);
    end
  endtask

  task automatic test_fixed_delay();
    do_reset();
    cfg_mode = 2'd1;
    cfg_delay = 4'd3;
    bus.ch_valid_i[0] = 1'b1;
    exp_q = {0, 0, 0, 1};
    for (int c = 1; c <= 4; c++) begin
      int e;
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (int'(bus.ch_pass_o[0]) !== e) begin
        n_fail++; $display("FAIL fixed3_cycle%0d: got %b want %0d", c, bus.ch_pass_o[0], e);
      end
    end
    tick();
    bus.ch_valid_i[0] = 1'b0;
    #1;
    n_checks++;
    if (bus.ch_pass_o[0] !== 1'b0 || aw_out !== 4'd1) begin
      n_fail++; $display("FAIL fixed3_after_hs: pass %b cnt %0d want 0/1", bus.ch_pass_o[0], aw_out);
    end
  endtask

  task automatic test_zero_delay();
    int beats = 0;
    do_reset();
    cfg_mode = 2'd1;
    cfg_delay = 4'd0;
    bus.ch_valid_i[1] = 1'b1;
    exp_q = {1, 0, 1, 0, 1, 0, 1, 0};
    for (int c = 1; c <= 8; c++) begin
      int e;
      tick();
      e = exp_q.pop_front();
      if (bus.ch_pass_o[1]) beats++;
      n_checks++;
      if (int'(bus.ch_pass_o[1]) !== e) begin
        n_fail++; $display("FAIL zero_delay_cycle%0d: got %b want %0d", c, bus.ch_pass_o[1], e);
      end
    end
    bus.ch_valid_i[1] = 1'b0;
    n_checks++;
    if (beats !== 4) begin
      n_fail++; $display("FAIL zero_delay_beats: got %0d want 4", beats);
    end
  endtask

  task automatic test_random_delay();
    do_reset();
    cfg_mode = 2'd2;
    cfg_delay = 4'hF;
    tick();
    tick();
    seed = 16'h0000;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    n_checks++;
    if (dut.lfsr_q !== 16'hACE1) begin
      n_fail++; $display("FAIL seed_zero_lfsr: got %h want ace1", dut.lfsr_q);
    end
    for (int b = 0; b < 1000; b++) begin
      int ch;
      int k;
      int e;
      logic [15:0] t;
      ch = b % 5;
      if (b == 500) cfg_delay = 4'h9;
      bus.ch_valid_i[ch] = 1'b1;
      t = m_lfsr >> (3 * ch);
      exp_q.push_back(int'(t[3:0] & cfg_delay));
      tick();
      k = 0;
      while (!bus.ch_pass_o[ch] && k < 20) begin
        tick();
        k++;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (k !== e) begin
        n_fail++; $display("FAIL rand_beat%0d_ch%0d: delay %0d want %0d", b, ch, k, e);
      end
      tick();
      bus.ch_valid_i[ch] = 1'b0;
    end
  endtask

  task automatic test_outstanding();
    do_reset();
    cfg_mode = 2'd0;
    bus.ch_ready_i = '1;
    for (int n = 1; n <= 8; n++) begin
      int e;
      bus.ch_valid_i[0] = 1'b1;
      exp_q.push_back(n);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if (int'(aw_out) !== e) begin
        n_fail++; $display("FAIL aw_count%0d: got %0d want %0d", n, aw_out, e);
      end
    end
    #1;
    n_checks++;
    if (bus.ch_pass_o[0] !== 1'b0) begin
      n_fail++; $display("FAIL aw_throttle: pass %b want 0", bus.ch_pass_o[0]);
    end
    tick();
    n_checks++;
    if (aw_out !== 4'd8) begin
      n_fail++; $display("FAIL aw_blocked_count: got %0d want 8", aw_out);
    end
    bus.ch_valid_i[2] = 1'b1;
    tick();
    n_checks++;
    if (aw_out !== 4'd7 || bus.ch_pass_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL b_release: cnt %0d pass %b want 7/1", aw_out, bus.ch_pass_o[0]);
    end
    tick();
    n_checks++;
    if (aw_out !== 4'd7) begin
      n_fail++; $display("FAIL simul_aw_b: got %0d want 7", aw_out);
    end
    bus.ch_valid_i[2] = 1'b0;
    tick();
    bus.ch_valid_i[0] = 1'b0;
    n_checks++;
    if (aw_out !== 4'd8) begin
      n_fail++; $display("FAIL aw_refill: got %0d want 8", aw_out);
    end
    bus.ch_valid_i[2] = 1'b1;
    for (int n = 0; n < 9; n++) tick();
    bus.ch_valid_i[2] = 1'b0;
    n_checks++;
    if (aw_out !== 4'd0) begin
      n_fail++; $display("FAIL b_floor: got %0d want 0", aw_out);
    end
  endtask

  task automatic test_bypass_switch();
    int k = 0;
    do_reset();
    cfg_mode = 2'd1;
    cfg_delay = 4'd5;
    bus.ch_valid_i[1] = 1'b1;
    tick();
    cfg_mode = 2'd0;
    #1;
    n_checks++;
    if (bus.ch_pass_o !== 5'b11111) begin
      n_fail++; $display("FAIL bypass_switch_pass: got %b want 11111", bus.ch_pass_o);
    end
    tick();
    cfg_mode = 2'd1;
    tick();
    while (!bus.ch_pass_o[1] && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (k !== 5) begin
      n_fail++; $display("FAIL bypass_forces_idle: delay %0d want 5", k);
    end
    tick();
    bus.ch_valid_i[1] = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    cfg_mode = 2'd0;
    bus.ch_valid_i[0] = 1'b1;
    tick();
    bus.ch_valid_i[0] = 1'b0;
    cfg_mode = 2'd1;
    cfg_delay = 4'd5;
    bus.ch_valid_i[4] = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (bus.ch_pass_o[4] !== 1'b0 || aw_out !== 4'd1) begin
      n_fail++; $display("FAIL midflight_pre: pass %b cnt %0d want 0/1", bus.ch_pass_o[4], aw_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.ch_pass_o !== 5'b00000 || aw_out !== 4'd0) begin
      n_fail++; $display("FAIL midflight_async: pass %b cnt %0d want 00000/0", bus.ch_pass_o, aw_out);
    end
    bus.ch_valid_i[4] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (bus.ch_pass_o !== 5'b00000 || aw_out !== 4'd0) begin
        n_fail++; $display("FAIL midflight_resume%0d: pass %b cnt %0d want 00000/0", c, bus.ch_pass_o, aw_out);
      end
    end
  endtask

  task automatic test_stats();
    int k = 0;
    int e;
    do_reset();
    cfg_mode = 2'd1;
    cfg_delay = 4'd5;
    bus.ch_valid_i[3] = 1'b1;
`ifdef AXI_DELAY_CTRL_STATS_EN
    exp_q.push_back(6);
`else
    exp_q.push_back(0);
`endif
    tick();
    while (!bus.ch_pass_o[3] && k < 20) begin
      tick();
      k++;
    end
    n_checks++;
    if (k !== 5) begin
      n_fail++; $display("FAIL ar_delay5: delay %0d want 5", k);
    end
    tick();
    bus.ch_valid_i[3] = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if (int'(stall) !== e) begin
      n_fail++; $display("FAIL stall_cycles: got %0d want %0d", stall, e);
    end
  endtask

  initial begin
    bus.ch_valid_i = '0;
    bus.ch_ready_i = '1;
    test_reset();
    test_fixed_delay();
    test_zero_delay();
    test_random_delay();
    test_outstanding();
    test_bypass_switch();
    test_reset_midflight();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
